// File: rtl/bmc_soft_pipe.sv
// Two-stage soft-decision branch-metric unit: per symbol of N soft bits it emits
// the distance to all 2^N labels, with erasures, valid/ready flow and frame tracking.
module bmc_soft_pipe #(
  parameter int unsigned N     = 2,
  parameter int unsigned Q     = 3,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned MAX  = (1 << Q) - 1,
  localparam int unsigned BMW  = $clog2(N * MAX + 1),
  localparam int unsigned L    = 1 << N
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*Q-1:0]     in_sym,
  input  logic [N-1:0]       in_erase,
  input  logic               in_first,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [L*BMW-1:0]   out_bm,
  output logic               out_first,
  output logic               out_last,
  output logic [CNT_W-1:0]   sym_count,
  output logic               frame_err
);

  logic adv1, adv2, accept;

  logic                 s1_valid_q, s1_valid_d;
  logic [N-1:0][Q-1:0]  s1_d0_q, s1_d0_d;
  logic [N-1:0][Q-1:0]  s1_d1_q, s1_d1_d;
  logic                 s1_first_q, s1_first_d;
  logic                 s1_last_q, s1_last_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [L-1:0][BMW-1:0] s2_bm_q, s2_bm_d;
  logic                 s2_first_q, s2_first_d;
  logic                 s2_last_q, s2_last_d;

  logic [CNT_W-1:0]     sym_count_q, sym_count_d;
  logic                 in_frame_q, in_frame_d;
  logic                 frame_err_q, frame_err_d;

  logic [BMW-1:0]       acc;
  logic [Q-1:0]         r;

  always_comb begin
    adv2     = !s2_valid_q || out_ready;
    adv1     = !s1_valid_q || adv2;
    in_ready = adv1 && rst_n;
    accept   = in_valid && in_ready;
  end

  // Stage 1: distance to a '0' is r, to a '1' is MAX - r (= ~r); erased bits give 0.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d0_d    = s1_d0_q;
    s1_d1_d    = s1_d1_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    r          = '0;
    if (adv1) begin
      s1_valid_d = accept;
      if (accept) begin
        for (int i = 0; i < N; i++) begin
          r          = in_sym[i*Q +: Q];
          s1_d0_d[i] = in_erase[i] ? '0 : r;
          s1_d1_d[i] = in_erase[i] ? '0 : ~r;
        end
        s1_first_d = in_first;
        s1_last_d  = in_last;
      end
    end
  end

  // Stage 2: each label picks d1 or d0 per code bit according to its own bit pattern.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_bm_d    = s2_bm_q;
    s2_first_d = s2_first_q;
    s2_last_d  = s2_last_q;
    acc        = '0;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int c = 0; c < L; c++) begin
          acc = '0;
          for (int i = 0; i < N; i++) begin
            acc = acc + BMW'(((c >> i) & 1) != 0 ? s1_d1_q[i] : s1_d0_q[i]);
          end
          s2_bm_d[c] = acc;
        end
        s2_first_d = s1_first_q;
        s2_last_d  = s1_last_q;
      end
    end
  end

  always_comb begin
    sym_count_d = sym_count_q;
    in_frame_d  = in_frame_q;
    frame_err_d = frame_err_q;
    if (accept) begin
      if (in_first) begin
        if (in_frame_q) frame_err_d = 1'b1;
        sym_count_d = CNT_W'(1);
        in_frame_d  = !in_last;
      end else if (!in_frame_q) begin
        frame_err_d = 1'b1;
      end else begin
        if (sym_count_q != '1) sym_count_d = sym_count_q + CNT_W'(1);
        if (in_last) in_frame_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_d0_q     <= '0;
      s1_d1_q     <= '0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_bm_q     <= '0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      sym_count_q <= '0;
      in_frame_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_d0_q     <= s1_d0_d;
      s1_d1_q     <= s1_d1_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_bm_q     <= s2_bm_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      sym_count_q <= sym_count_d;
      in_frame_q  <= in_frame_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_bm    = s2_bm_q;
  assign out_first = s2_first_q;
  assign out_last  = s2_last_q;
  assign sym_count = sym_count_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Bench for bmc_soft_pipe: default build (N=2,Q=3) plus a hard-decision
// build (N=2,Q=1,CNT_W=3) for Hamming distances and counter saturation.
module tb_bmc_soft_pipe;

  logic clk = 1'b0;
  logic rst_n;

  logic        in_valid, in_ready, in_first, in_last;
  logic [5:0]  in_sym;
  logic [1:0]  in_erase;
  logic        out_valid, out_ready, out_first, out_last;
  logic [15:0] out_bm;
  logic [15:0] sym_count;
  logic        frame_err;

  logic        h_in_valid, h_in_ready, h_in_first, h_in_last;
  logic [1:0]  h_in_sym;
  logic [1:0]  h_in_erase;
  logic        h_out_valid, h_out_ready, h_out_first, h_out_last;
  logic [7:0]  h_out_bm;
  logic [2:0]  h_sym_count;
  logic        h_frame_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bmc_soft_pipe #(.N(2), .Q(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_erase(in_erase),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_bm(out_bm),
    .out_first(out_first), .out_last(out_last),
    .sym_count(sym_count), .frame_err(frame_err)
  );

  bmc_soft_pipe #(.N(2), .Q(1), .CNT_W(3)) dut_hard (
    .clk(clk), .rst_n(rst_n),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_sym(h_in_sym), .in_erase(h_in_erase),
    .in_first(h_in_first), .in_last(h_in_last),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_bm(h_out_bm),
    .out_first(h_out_first), .out_last(h_out_last),
    .sym_count(h_sym_count), .frame_err(h_frame_err)
  );

  typedef struct {
    logic [5:0]  sym;
    logic [1:0]  erase;
    logic [15:0] exp_bm;
  } soft_vec_t;

  typedef struct {
    logic [1:0] sym;
    logic [7:0] exp_bm;
  } hard_vec_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Metric of every label from the textbook definition: sum of per-bit soft distances.
  function automatic logic [15:0] model_bm(input logic [5:0] sym, input logic [1:0] er);
    logic [15:0] res;
    int s, rv;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      s = 0;
      for (int i = 0; i < 2; i++) begin
        rv = int'((sym >> (3 * i)) & 6'd7);
        if (!er[i]) s += (((c >> i) & 1) != 0) ? (7 - rv) : rv;
      end
      res[c*4 +: 4] = s[3:0];
    end
    return res;
  endfunction

  // Present one symbol at a negedge, hold until accepted, return at the following negedge.
  task automatic applyStimulus(input logic [5:0] sym, input logic [1:0] er,
                               input logic first, input logic last);
    int waitc;
    bit ok;
    waitc = 0;
    ok = 1'b1;
    in_valid = 1'b1; in_sym = sym; in_erase = er; in_first = first; in_last = last;
    #1;
    while (!in_ready && ok) begin
      @(negedge clk); #1;
      waitc++;
      if (waitc > 50) ok = 1'b0;
    end
    if (!ok) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic applyHard(input logic [1:0] sym, input logic first, input logic last);
    int waitc;
    bit ok;
    waitc = 0;
    ok = 1'b1;
    h_in_valid = 1'b1; h_in_sym = sym; h_in_first = first; h_in_last = last;
    #1;
    while (!h_in_ready && ok) begin
      @(negedge clk); #1;
      waitc++;
      if (waitc > 50) ok = 1'b0;
    end
    if (!ok) begin
      checks++; errors++;
      $display("[TB] FAIL hard_accept_timeout: in_ready stayed %0b, expected 1", h_in_ready);
      h_in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    h_in_valid = 1'b0;
  endtask

  soft_vec_t soft_tab[5];
  hard_vec_t hard_tab[4];
  logic [5:0] rs[20];
  logic [1:0] re[20];
  logic [17:0] q[$];
  logic [17:0] expv;
  logic [15:0] held_bm;
  logic held_first, held_last, stalled;
  int sent, got, cyc, inflight, seen_valid;

  initial begin
    soft_tab[0] = '{6'd56, 2'b00, {4'd7, 4'd0, 4'd14, 4'd7}};
    soft_tab[1] = '{6'd56, 2'b10, {4'd7, 4'd0, 4'd7,  4'd0}};
    soft_tab[2] = '{6'd56, 2'b11, 16'h0000};
    soft_tab[3] = '{6'd29, 2'b00, {4'd6, 4'd9, 4'd5,  4'd8}};
    soft_tab[4] = '{6'd7,  2'b01, {4'd7, 4'd7, 4'd0,  4'd0}};
    hard_tab[0] = '{2'b00, {2'd2, 2'd1, 2'd1, 2'd0}};
    hard_tab[1] = '{2'b01, {2'd1, 2'd2, 2'd0, 2'd1}};
    hard_tab[2] = '{2'b10, {2'd1, 2'd0, 2'd2, 2'd1}};
    hard_tab[3] = '{2'b11, {2'd0, 2'd1, 2'd1, 2'd2}};

    rst_n = 1'b0;
    in_valid = 1'b1; in_sym = '0; in_erase = '0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    h_in_valid = 1'b0; h_in_sym = '0; h_in_erase = '0; h_in_first = 1'b0; h_in_last = 1'b0;
    h_out_ready = 1'b1;

    #3;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_bm", out_bm, 0);
    checkOutput("reset_sym_count", sym_count, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed soft vectors, each a one-symbol frame; result two edges after acceptance.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(soft_tab[k].sym, soft_tab[k].erase, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("soft_vec%0d_bm", k), {out_valid, out_bm}, {1'b1, soft_tab[k].exp_bm});
      if (k == 0) begin
        checkOutput("soft_vec0_flags", {out_first, out_last}, 2'b11);
        checkOutput("soft_vec0_count", sym_count, 1);
      end
    end

    for (int k = 0; k < 4; k++) begin
      applyHard(hard_tab[k].sym, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("hard_vec%0d_bm", k), {h_out_valid, h_out_bm}, {1'b1, hard_tab[k].exp_bm});
    end

    for (int k = 1; k <= 10; k++) begin
      applyHard(2'($urandom), k == 1, k == 10);
      if (k == 7) checkOutput("hard_count_7", h_sym_count, 7);
    end
    checkOutput("hard_count_sat", h_sym_count, 7);
    checkOutput("hard_frame_err", h_frame_err, 0);

    // Random stream of one 20-symbol frame against a queue model with random backpressure.
    for (int k = 0; k < 20; k++) begin
      rs[k] = 6'($urandom);
      re[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
    end
    q.delete();
    sent = 0; got = 0; cyc = 0; stalled = 1'b0;
    held_bm = '0; held_first = 1'b0; held_last = 1'b0;
    while (got < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        in_valid = 1'b1; in_sym = rs[sent]; in_erase = re[sent];
        in_first = (sent == 0); in_last = (sent == 19);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      inflight = sent - got;
      checkOutput("stream_in_ready", in_ready, !(inflight == 2 && !out_ready));
      if (stalled)
        checkOutput("stream_stall_hold", {out_valid, out_bm, out_first, out_last},
                    {1'b1, held_bm, held_first, held_last});
      stalled = out_valid && !out_ready;
      held_bm = out_bm; held_first = out_first; held_last = out_last;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL stream_dup: got output %0h, expected none", out_bm);
        end else begin
          expv = q.pop_front();
          checkOutput("stream_out", {out_bm, out_first, out_last}, expv);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back({model_bm(rs[sent], re[sent]), sent == 0, sent == 19});
        sent++;
      end
    end
    in_valid = 1'b0;
    checkOutput("stream_all_out", got, 20);
    checkOutput("stream_queue_empty", q.size(), 0);
    checkOutput("stream_count", sym_count, 20);
    checkOutput("stream_frame_err", frame_err, 0);

    // Framing: 5-symbol frame, then a stray symbol, then a fresh frame start.
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) applyStimulus(6'($urandom), 2'b00, k == 1, k == 5);
    checkOutput("frame5_count", sym_count, 5);
    checkOutput("frame5_err", frame_err, 0);
    applyStimulus(6'($urandom), 2'b00, 1'b0, 1'b0);
    checkOutput("stray_err", frame_err, 1);
    applyStimulus(6'($urandom), 2'b00, 1'b1, 1'b0);
    checkOutput("sticky_err", frame_err, 1);
    checkOutput("restart_count", sym_count, 1);
    repeat (3) @(negedge clk);

    // Fill both stages under stall, then reset asynchronously mid-cycle.
    out_ready = 1'b0;
    applyStimulus(6'd11, 2'b00, 1'b0, 1'b0);
    applyStimulus(6'd22, 2'b00, 1'b0, 1'b0);
    in_valid = 1'b1; in_sym = 6'd33; in_first = 1'b0; in_last = 1'b0;
    #1;
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    checkOutput("rst_sym_count", sym_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", in_ready, 1);
    seen_valid = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (out_valid) seen_valid++;
    end
    checkOutput("no_stale_output", seen_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
